// File: rtl/timer_cmd_tx_if.sv
// Pin bundle between the host-side command transmitter and the remote timer.
// The master side is the host or test driver; the slave side is the transmitter itself.
interface timer_cmd_tx_if;
    logic       start;
    logic [3:0] delay;
    logic       done;
    logic       x;
    logic       busy;
    logic       ack;
    logic       timeout;

    modport master (output start, delay, done, input x, busy, ack, timeout);
    modport slave  (input start, delay, done, output x, busy, ack, timeout);
endinterface

// File: rtl/timer_cmd_tx.sv
// Serialises a timer request (preamble 1101 + 4-bit delay, MSB first) onto x,
// then waits for the remote done, acks it for one cycle, with a watchdog on the wait.
module timer_cmd_tx #(
    parameter int COUNT_CYCLES = 1000,
    parameter int SLACK        = 16,
    parameter int WD_W         = 16
) (
    input  logic           clk,
    input  logic           reset,
    timer_cmd_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_WAIT = 3'd3,
        S_ACK  = 3'd4
    } state_t;

    localparam logic [WD_W-1:0] CC_W    = WD_W'(COUNT_CYCLES);
    localparam logic [WD_W-1:0] SLACK_W = WD_W'(SLACK);

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [3:0]      r_delay;
    logic [WD_W-1:0] r_wd;
    logic            r_x;
    logic            r_busy;
    logic            r_ack;
    logic            r_timeout;
    logic [WD_W-1:0] w_limit;

    // Preamble 1101 indexed from the first transmitted bit.
    function automatic logic pre_bit(input logic [1:0] i);
        return (i != 2'd2);
    endfunction

    function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign w_limit = ({{(WD_W-4){1'b0}}, r_delay} + 1'b1) * CC_W + SLACK_W;

    assign bus.x       = r_x;
    assign bus.busy    = r_busy;
    assign bus.ack     = r_ack;
    assign bus.timeout = r_timeout;

    // Outputs are loaded with the value belonging to the state being entered,
    // so x/busy/ack line up with the state held in the flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_delay   <= 4'd0;
            r_wd      <= '0;
            r_x       <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_x    <= 1'b0;
                    r_ack  <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_delay   <= bus.delay;
                        r_timeout <= 1'b0;
                        r_idx     <= 2'd0;
                        r_state   <= S_PRE;
                        r_x       <= pre_bit(2'd0);
                        r_busy    <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (r_idx == 2'd3) begin
                        r_idx   <= 2'd0;
                        r_state <= S_DATA;
                        r_x     <= r_delay[3];
                    end else begin
                        r_idx <= r_idx + 2'd1;
                        r_x   <= pre_bit(r_idx + 2'd1);
                    end
                end
                S_DATA: begin
                    if (r_idx == 2'd3) begin
                        r_state <= S_WAIT;
                        r_wd    <= '0;
                        r_x     <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                        r_x   <= r_delay[2'd2 - r_idx];
                    end
                end
                S_WAIT: begin
                    r_x <= 1'b0;
                    // done takes priority over a watchdog expiry in the same cycle.
                    if (bus.done) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end else if (r_wd == w_limit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_wd <= sat_inc(r_wd);
                    end
                end
                S_ACK: begin
                    r_ack   <= 1'b0;
                    r_x     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_x     <= 1'b0;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_cmd_tx.sv
// Bench for timer_cmd_tx: scoreboarded bitstream checks, ack/timeout paths,
// and a behavioural remote timer for the paired scenario.
module tb_timer_cmd_tx;

    localparam int CC = 4;
    localparam int SL = 2;
    localparam int RS_SEARCH = 0, RS_SHIFT = 1, RS_COUNT = 2, RS_DONE = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tb_done = 1'b0;
    logic paired = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    timer_cmd_tx_if bus();

    timer_cmd_tx #(.COUNT_CYCLES(CC), .SLACK(SL), .WD_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Remote timer: search 1101, shift 4 delay bits, count (d+1)*CC, hold done until ack.
    int         rem_st;
    logic [3:0] rem_sh, rem_d;
    int         rem_n, rem_cnt;
    logic       rem_counting, rem_done;

    always @(posedge clk) begin
        if (reset || !paired) begin
            rem_st <= RS_SEARCH; rem_sh <= 4'd0; rem_d <= 4'd0; rem_n <= 0; rem_cnt <= 0;
        end else begin
            case (rem_st)
                RS_SEARCH: begin
                    rem_sh <= {rem_sh[2:0], bus.x};
                    if ({rem_sh[2:0], bus.x} == 4'b1101) begin rem_st <= RS_SHIFT; rem_n <= 0; end
                end
                RS_SHIFT: begin
                    rem_d <= {rem_d[2:0], bus.x};
                    rem_n <= rem_n + 1;
                    if (rem_n == 3) begin rem_st <= RS_COUNT; rem_cnt <= 0; end
                end
                RS_COUNT: begin
                    if (rem_cnt == (int'(rem_d) + 1) * CC - 1) rem_st <= RS_DONE;
                    else rem_cnt <= rem_cnt + 1;
                end
                default: if (bus.ack) begin rem_st <= RS_SEARCH; rem_sh <= 4'd0; end
            endcase
        end
    end

    assign rem_counting = (rem_st == RS_COUNT);
    assign rem_done     = (rem_st == RS_DONE);
    assign bus.done     = paired ? rem_done : tb_done;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [3:0] d);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        for (int i = 3; i >= 0; i--) exp_q.push_back(d[i]);
    endtask

    task automatic launch(input logic [3:0] d);
        push_frame(d);
        bus.delay = d;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.delay = ~d;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        checks++; if (bus.x !== 1'b0) begin errors++; $display("FAIL reset_x: got %b want 0", bus.x); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
        reset = 1'b0;
        tick;
        checks++; if (bus.x !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got x=%b busy=%b want 0 0", bus.x, bus.busy); end
    endtask

    task automatic test_frame_ack;
        logic e;
        launch(4'b1010);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.x !== e) begin errors++; $display("FAIL frame_x[%0d]: got %b want %b", i, bus.x, e); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL frame_busy[%0d]: got %b want 1", i, bus.busy); end
            tick;
        end
        for (int w = 0; w < 5; w++) begin
            checks++; if (bus.x !== 1'b0 || bus.ack !== 1'b0 || bus.busy !== 1'b1) begin
                errors++; $display("FAIL wait[%0d]: got x=%b ack=%b busy=%b want 0 0 1", w, bus.x, bus.ack, bus.busy); end
            tick;
        end
        tb_done = 1'b1;
        tick;
        tb_done = 1'b0;
        checks++; if (bus.ack !== 1'b1 || bus.busy !== 1'b1 || bus.x !== 1'b0) begin
            errors++; $display("FAIL ack_cycle: got ack=%b busy=%b x=%b want 1 1 0", bus.ack, bus.busy, bus.x); end
        tick;
        checks++; if (bus.ack !== 1'b0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++; $display("FAIL after_ack: got ack=%b busy=%b timeout=%b want 0 0 0", bus.ack, bus.busy, bus.timeout); end
    endtask

    task automatic test_timeout;
        logic e;
        launch(4'd0);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.x !== e) begin errors++; $display("FAIL to_frame_x[%0d]: got %b want %b", i, bus.x, e); end
            tick;
        end
        // limit = (0+1)*4+2 = 6: WAIT cycles with wd = 0..6, expiry on the edge ending wd==6
        for (int w = 0; w <= CC + SL; w++) begin
            checks++; if (bus.timeout !== 1'b0 || bus.busy !== 1'b1 || bus.ack !== 1'b0) begin
                errors++; $display("FAIL to_wait[%0d]: got timeout=%b busy=%b ack=%b want 0 1 0", w, bus.timeout, bus.busy, bus.ack); end
            tick;
        end
        checks++; if (bus.timeout !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
            errors++; $display("FAIL to_fired: got timeout=%b busy=%b ack=%b want 1 0 0", bus.timeout, bus.busy, bus.ack); end
        tick; tick;
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", bus.timeout); end
        launch(4'd3);
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", bus.timeout); end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.x !== e) begin errors++; $display("FAIL to_frame2_x[%0d]: got %b want %b", i, bus.x, e); end
            tick;
        end
        tb_done = 1'b1; tick; tb_done = 1'b0;
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL to_ack2: got %b want 1", bus.ack); end
        tick;
    endtask

    task automatic test_ignored;
        logic e;
        launch(4'b0110);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.x !== e || bus.ack !== 1'b0) begin
                errors++; $display("FAIL ign_x[%0d]: got x=%b ack=%b want %b 0", i, bus.x, bus.ack, e); end
            if (i == 1) bus.start = 1'b1;
            if (i == 5 || i == 7) tb_done = 1'b1;
            bus.delay = 4'($urandom);
            tick;
            bus.start = 1'b0;
            tb_done = 1'b0;
        end
        checks++; if (bus.x !== 1'b0 || bus.ack !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL ign_wait0: got x=%b ack=%b busy=%b want 0 0 1", bus.x, bus.ack, bus.busy); end
        bus.start = 1'b1; tick; bus.start = 1'b0;
        checks++; if (bus.x !== 1'b0 || bus.ack !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL ign_wait_start: got x=%b ack=%b busy=%b want 0 0 1", bus.x, bus.ack, bus.busy); end
        tb_done = 1'b1; tick; tb_done = 1'b0;
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL ign_ack: got %b want 1", bus.ack); end
        tick;
        checks++; if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
            errors++; $display("FAIL ign_idle: got busy=%b ack=%b want 0 0", bus.busy, bus.ack); end
    endtask

    task automatic test_reset_mid;
        logic e;
        launch(4'b1111);
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.x !== e) begin errors++; $display("FAIL rm_x[%0d]: got %b want %b", i, bus.x, e); end
            tick;
        end
        exp_q.delete();
        reset = 1'b1; tick; reset = 1'b0;
        checks++; if (bus.x !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rm_abort: got x=%b busy=%b want 0 0", bus.x, bus.busy); end
        tick;
        checks++; if (bus.x !== 1'b0) begin errors++; $display("FAIL rm_quiet: got %b want 0", bus.x); end
        launch(4'b1001);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.x !== e || bus.busy !== 1'b1) begin
                errors++; $display("FAIL rm_frame_x[%0d]: got x=%b busy=%b want %b 1", i, bus.x, bus.busy, e); end
            tick;
        end
        tb_done = 1'b1; tick; tb_done = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic e;
        launch(4'b0011);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.x !== e) begin errors++; $display("FAIL b2b1_x[%0d]: got %b want %b", i, bus.x, e); end
            tick;
        end
        tb_done = 1'b1; tick; tb_done = 1'b0;
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL b2b_ack: got %b want 1", bus.ack); end
        tick;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b want 0", bus.busy); end
        launch(4'b1100);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.x !== e || bus.busy !== 1'b1) begin
                errors++; $display("FAIL b2b2_x[%0d]: got x=%b busy=%b want %b 1", i, bus.x, bus.busy, e); end
            tick;
        end
        tb_done = 1'b1; tick; tb_done = 1'b0;
        tick;
    endtask

    task automatic test_paired;
        logic e;
        int   n_count, n_ack, n_done;
        paired = 1'b1;
        tick;
        launch(4'd2);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.x !== e) begin errors++; $display("FAIL pair_x[%0d]: got %b want %b", i, bus.x, e); end
            tick;
        end
        n_count = 0; n_ack = 0; n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (rem_counting) n_count++;
            if (rem_done) n_done++;
            if (bus.ack === 1'b1) n_ack++;
            tick;
        end
        checks++; if (n_count != 3 * CC) begin errors++; $display("FAIL pair_counting: got %0d want %0d", n_count, 3 * CC); end
        checks++; if (n_ack != 1) begin errors++; $display("FAIL pair_ack_pulses: got %0d want 1", n_ack); end
        checks++; if (n_done == 0) begin errors++; $display("FAIL pair_done_seen: got %0d want >0", n_done); end
        checks++; if (bus.busy !== 1'b0 || bus.timeout !== 1'b0 || rem_st != RS_SEARCH) begin
            errors++; $display("FAIL pair_idle: got busy=%b timeout=%b rem_st=%0d want 0 0 0", bus.busy, bus.timeout, rem_st); end
        paired = 1'b0;
        tick;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.delay = 4'd0;
        test_reset;
        test_frame_ack;
        test_timeout;
        test_ignored;
        test_reset_mid;
        test_back_to_back;
        test_paired;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
